// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream, packs bytes big-endian
// into 32-bit words, writes them to instruction memory and holds the CPU until done.
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  IDLE_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [16:0]       MAX_LEN    = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [31:0]         shift_q, shift_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]    idle_q, idle_d;
  logic                rx_ready_s;
  logic                accept_s;

  assign rx_ready_s = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign accept_s   = rx_valid_i && rx_ready_s;

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      shift_q    <= 32'd0;
      byte_idx_q <= 2'd0;
      word_cnt_q <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      idle_q     <= idle_d;
    end
  end

  // Next-state logic, byte packing and idle timeout.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    idle_d     = idle_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN_HI;
          shift_d    = 32'd0;
          byte_idx_d = 2'd0;
          word_cnt_d = '0;
          idle_d     = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        // A byte arriving on the last allowed idle cycle wins over the timeout.
        if (accept_s) begin
          idle_d = '0;
          case (state_q)
            S_LEN_HI: begin
              len_d   = {rx_data_i, len_q[7:0]};
              state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
              len_d = {len_q[15:8], rx_data_i};
              if (len_d == 16'd0) begin
                state_d = S_DONE;
              end else if ({1'b0, len_d} > MAX_LEN) begin
                state_d = S_ERR;
              end else begin
                state_d = S_DATA;
              end
            end
            S_DATA: begin
              shift_d    = {shift_q[23:0], rx_data_i};
              byte_idx_d = byte_idx_q + 2'd1;
              if (byte_idx_q == 2'd3) begin
                state_d = S_WRITE;
              end else begin
                state_d = S_DATA;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else if (idle_q == IDLE_LIMIT) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
        idle_d     = '0;
        if (32'(word_cnt_d) == 32'(len_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_ready_o   = rx_ready_s;
  assign mem_we_o     = (state_q == S_WRITE);
  assign mem_addr_o   = {{(29 - ADDR_W){1'b0}}, word_cnt_q, 2'b00};
  assign mem_wdata_o  = shift_q;
  assign cpu_hold_o   = (state_q != S_DONE);
  assign busy_o       = rx_ready_s || (state_q == S_WRITE);
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERR);
  assign word_count_o = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: the driver queues expected memory writes,
// an independent monitor pops and compares each write as mem_we is seen.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .TIMEOUT(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_ready_o(rx_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .cpu_hold_o(cpu_hold), .busy_o(busy), .done_o(done), .error_o(error),
    .word_count_o(word_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h@%h expected=none", mem_wdata, mem_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("rdy_low_in_write", {31'd0, rx_ready}, 32'd0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) begin
      @(negedge clk); rx_valid = 1'b0;
    end
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    budget = 100;
    while (!rx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait actual=0 expected=1");
    end
    @(posedge clk); #1;
  endtask

  function automatic int pick_gap(input int mode);
    case (mode)
      0:       return 0;
      1:       return 1;
      2:       return int'($urandom_range(0, 3));
      default: return 8;
    endcase
  endfunction

  // Full load: words come from prog; expectations follow the stream rules directly.
  task automatic run_load(input logic [15:0] len, input int mode);
    int          nw;
    logic [31:0] w;
    int          budget;
    bit          oversize;
    wr_t         e;
    oversize = (len > 16'd256);
    nw = oversize ? 0 : int'(len);
    for (int i = 0; i < nw; i++) begin
      e.addr = 32'(i * 4);
      e.data = prog[i];
      exp_q.push_back(e);
    end
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    send_byte(len[15:8], pick_gap(mode));
    send_byte(len[7:0], pick_gap(mode));
    for (int i = 0; i < nw; i++) begin
      w = prog[i];
      for (int j = 0; j < 4; j++) send_byte(w[31 - 8*j -: 8], pick_gap(mode));
    end
    @(negedge clk); rx_valid = 1'b0;
    budget = 50;
    while (!(done || error) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("end_done", {31'd0, done}, {31'd0, !oversize});
    chk("end_error", {31'd0, error}, {31'd0, oversize});
    chk("end_hold", {31'd0, cpu_hold}, {31'd0, oversize});
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_word_count", 32'(word_count), 32'(nw));
    chk("end_pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_random(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  initial begin
    int k;
    wr_t e;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    #12;
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", {31'd0, rx_ready}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    prog.delete(); prog.push_back(32'h2008_0005); prog.push_back(32'hAC01_0004);
    run_load(16'd2, 0);
    run_load(16'd2, 1);
    run_load(16'd0, 2);
    run_load(16'h0101, 2);
    fill_random(256);
    run_load(16'h0100, 2);
    for (int t = 0; t < 4; t++) begin
      k = int'($urandom_range(1, 12));
      fill_random(k);
      run_load(16'(k), 2);
    end
    fill_random(2);
    run_load(16'd2, 3);

    // Timeout: stream stops after three data bytes.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    rx_valid = 1'b0;
    k = 0;
    while (!error && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'd10);
    chk("timeout_hold", {31'd0, cpu_hold}, 32'd1);
    chk("timeout_wc", 32'(word_count), 32'd0);
    fill_random(3);
    run_load(16'd3, 2);

    // Reset after the first word has been written, then reload from address 0.
    fill_random(2);
    e.addr = 32'd0; e.data = prog[0];
    exp_q.push_back(e);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    for (int j = 0; j < 4; j++) send_byte(prog[0][31 - 8*j -: 8], 0);
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, rx_ready}, 32'd0);
    chk("midrst_wc", 32'(word_count), 32'd0);
    chk("midrst_first_written", 32'(exp_q.size()), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_load(16'd2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
